// File: rtl/bsort_pkg.sv
// Shared types and sizing helpers for the bubble-sort sequencing controller.
package bsort_pkg;

    // Controller states: load/wait, walk adjacent pairs, end-of-pass decision, completion pulse.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 4;

    // Width needed to hold a pair index or pass count (both range 0..DEPTH-2), never below one bit.
    function automatic int idx_width(input int depth);
        if (depth <= 2) begin
            return 1;
        end else begin
            return $clog2(depth);
        end
    endfunction

    // Width of the swap counter: a full sort of DEPTH entries needs at most DEPTH*(DEPTH-1)/2 swaps.
    function automatic int cnt_width(input int depth);
        return $clog2(depth * (depth - 1) / 2 + 1);
    endfunction

endpackage

// File: rtl/bubble_sort_ctrl_compare_swap.sv
// Single unsigned compare-swap element: orders two operands and flags when they were out of order.
// Equal operands are treated as already ordered so identical values never swap.
module compare_swap #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             swap
);

    // Strict greater-than decides the exchange; outputs route the smaller value to lo.
    always_comb begin
        swap = (a > b);
        if (swap) begin
            lo = b;
            hi = a;
        end else begin
            lo = a;
            hi = b;
        end
    end

endmodule

// File: rtl/bubble_sort_ctrl.sv
// Bubble-sort sequencing controller: owns the entry register file, loads entries by one-hot
// select, and on start walks one compare-swap unit over adjacent pairs pass by pass, stopping
// early after a pass with no swaps (or after DEPTH-1 passes, which always suffices).
module bubble_sort_ctrl
    import bsort_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       wr_en,
    input  logic [DEPTH-1:0]                           wr_sel,
    input  logic [WIDTH-1:0]                           wr_data,
    input  logic                                       start,
    output logic                                       busy,
    output logic                                       done,
    output logic [DEPTH*WIDTH-1:0]                     sorted_bus,
    output logic [$clog2(DEPTH*(DEPTH-1)/2+1)-1:0]     swap_cnt
);

    localparam int IW = idx_width(DEPTH);
    localparam int CW = $clog2(DEPTH * (DEPTH - 1) / 2 + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 2);

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     pass_q, pass_d;
    logic              swapped_q, swapped_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];

    logic [IW-1:0]     idx_nx_s;
    logic [WIDTH-1:0]  op_a_s, op_b_s, lo_s, hi_s;
    logic              swap_s;
    logic              wr_ok_s;

    // Select the adjacent pair entry[idx], entry[idx+1] that feeds the shared compare-swap unit.
    always_comb begin
        idx_nx_s = idx_q + IW'(1);
        op_a_s   = '0;
        op_b_s   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            op_a_s = (IW'(i) == idx_q)    ? mem_q[i] : op_a_s;
            op_b_s = (IW'(i) == idx_nx_s) ? mem_q[i] : op_b_s;
        end
    end

    compare_swap #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a    (op_a_s),
        .b    (op_b_s),
        .lo   (lo_s),
        .hi   (hi_s),
        .swap (swap_s)
    );

    // A load is only honoured when exactly one select bit is set.
    always_comb begin
        wr_ok_s = wr_en && $onehot(wr_sel);
    end

    // Next-state logic for the FSM, counters and register file.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pass_d    = pass_q;
        swapped_d = swapped_q;
        cnt_d     = cnt_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end

        case (state_q)
            IDLE, DONE: begin
                // Loads are accepted while not sorting; the sort starts on the updated contents.
                for (int i = 0; i < DEPTH; i++) begin
                    mem_d[i] = (wr_ok_s && wr_sel[i]) ? wr_data : mem_q[i];
                end
                if (start && (state_q == IDLE)) begin
                    state_d   = PASS;
                    idx_d     = '0;
                    pass_d    = '0;
                    swapped_d = 1'b0;
                    cnt_d     = '0;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            PASS: begin
                if (swap_s) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_d[i] = (IW'(i) == idx_q)    ? lo_s :
                                   (IW'(i) == idx_nx_s) ? hi_s : mem_q[i];
                    end
                    swapped_d = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                end else begin
                    swapped_d = swapped_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = CHECK;
                end else begin
                    idx_d = idx_nx_s;
                end
            end
            CHECK: begin
                // A clean pass proves order; DEPTH-1 passes guarantee it regardless.
                if (!swapped_q || (pass_q == LAST_IDX)) begin
                    state_d = DONE;
                end else begin
                    state_d   = PASS;
                    pass_d    = pass_q + IW'(1);
                    idx_d     = '0;
                    swapped_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == PASS) || (state_d == CHECK);
        done_d = (state_d == DONE);
    end

    // State, counters, register file and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pass_q    <= '0;
            swapped_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pass_q    <= pass_d;
            swapped_q <= swapped_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Flatten the register file onto the result bus, entry 0 in the least significant slot.
    always_comb begin
        sorted_bus = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sorted_bus[i*WIDTH +: WIDTH] = mem_q[i];
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign swap_cnt = cnt_q;

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Self-checking bench for bubble_sort_ctrl: directed test-plan cases with literal expectations,
// then randomized loads/starts/resets checked every cycle against an algorithmic reference.
module tb_bubble_sort_ctrl;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH * (DEPTH - 1) / 2 + 1);
    localparam int BW    = DEPTH * WIDTH;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             wr_en   = 1'b0;
    logic [DEPTH-1:0] wr_sel  = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             start   = 1'b0;
    logic             busy;
    logic             done;
    logic [BW-1:0]    sorted_bus;
    logic [CW-1:0]    swap_cnt;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    bubble_sort_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .sorted_bus (sorted_bus),
        .swap_cnt   (swap_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [BW-1:0] bus;
        bit            busy;
        bit            done;
        int            cnt;
    } snap_t;

    logic [BW-1:0] e_bus  = '0;
    bit            e_busy = 1'b0;
    bit            e_done = 1'b0;
    int            e_cnt  = 0;
    snap_t         traj[$];

    function automatic snap_t mk(input int a[DEPTH], input bit b, input bit d, input int c);
        snap_t s;
        s.bus = '0;
        for (int i = 0; i < DEPTH; i++) s.bus[i*WIDTH +: WIDTH] = a[i][WIDTH-1:0];
        s.busy = b;
        s.done = d;
        s.cnt  = c;
        return s;
    endfunction

    // Plain bubble sort with early exit; one snapshot per clock cycle after the start edge.
    task automatic build_traj(input logic [BW-1:0] bus);
        int a[DEPTH];
        int c, t;
        bit sw;
        c = 0;
        for (int i = 0; i < DEPTH; i++) a[i] = int'(bus[i*WIDTH +: WIDTH]);
        traj.push_back(mk(a, 1'b1, 1'b0, 0));
        for (int p = 0; p < DEPTH - 1; p++) begin
            sw = 1'b0;
            for (int j = 0; j < DEPTH - 1; j++) begin
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                    c++;
                    sw = 1'b1;
                end
                traj.push_back(mk(a, 1'b1, 1'b0, c));
            end
            if (!sw || p == DEPTH - 2) begin
                traj.push_back(mk(a, 1'b0, 1'b1, c));
                break;
            end
            traj.push_back(mk(a, 1'b1, 1'b0, c));
        end
    endtask

    task automatic apply_next();
        snap_t s;
        s      = traj.pop_front();
        e_bus  = s.bus;
        e_busy = s.busy;
        e_done = s.done;
        e_cnt  = s.cnt;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_bus = '0; e_busy = 1'b0; e_done = 1'b0; e_cnt = 0;
            traj.delete();
        end else if (traj.size() > 0) begin
            apply_next();
        end else begin
            bit was_done;
            was_done = e_done;
            e_done = 1'b0;
            e_busy = 1'b0;
            if (wr_en && $countones(wr_sel) == 1) begin
                for (int i = 0; i < DEPTH; i++)
                    if (wr_sel[i]) e_bus[i*WIDTH +: WIDTH] = wr_data;
            end
            if (start && !was_done) begin
                build_traj(e_bus);
                apply_next();
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("bus",      64'(sorted_bus), 64'(e_bus));
            check("busy",     64'(busy),       64'(e_busy));
            check("done",     64'(done),       64'(e_done));
            check("swap_cnt", 64'(swap_cnt),   64'(e_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input int val);
        wr_en   = 1'b1;
        wr_sel  = DEPTH'(1) << idx;
        wr_data = WIDTH'(val);
        tick();
        wr_en   = 1'b0;
        wr_sel  = '0;
    endtask

    task automatic load4(input int v0, input int v1, input int v2, input int v3);
        load(0, v0); load(1, v1); load(2, v2); load(3, v3);
    endtask

    // Start (optionally with a same-edge write), count edges until done; optional mid-sort junk.
    task automatic run_sort(input bit junk, input bit with_wr, input int wr_idx, input int wr_val,
                            output int n);
        start = 1'b1;
        if (with_wr) begin
            wr_en = 1'b1; wr_sel = DEPTH'(1) << wr_idx; wr_data = WIDTH'(wr_val);
        end
        tick();
        start = 1'b0; wr_en = 1'b0; wr_sel = '0;
        n = 0;
        while (n < 100) begin
            if (junk && n < 4) begin
                start = 1'b1; wr_en = 1'b1; wr_sel = 4'b0001; wr_data = 4'd9;
            end else begin
                start = 1'b0; wr_en = 1'b0; wr_sel = '0;
            end
            tick();
            n++;
            if (done) break;
        end
        start = 1'b0; wr_en = 1'b0; wr_sel = '0;
        if (!done) check("done_timeout", 64'(n), 64'(0));
        tick();
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_bus",  64'(sorted_bus), 64'(0));
        check("rst_cnt",  64'(swap_cnt), 64'(0));
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        tick();
        check("reset_bus", 64'(sorted_bus), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));

        // Worst case: three passes, five swaps.
        load4(3, 1, 2, 0);
        run_sort(1'b0, 1'b0, 0, 0, n);
        check("t1_cycles", 64'(n), 64'(12));
        check("t1_bus", 64'(sorted_bus), 64'h3210);
        check("t1_cnt", 64'(swap_cnt), 64'(5));

        // Already sorted: one clean pass.
        load4(1, 2, 3, 4);
        run_sort(1'b0, 1'b0, 0, 0, n);
        check("t2_cycles", 64'(n), 64'(4));
        check("t2_bus", 64'(sorted_bus), 64'h4321);
        check("t2_cnt", 64'(swap_cnt), 64'(0));

        // Duplicates, a rejected multi-select write, and inputs ignored while busy.
        load4(4, 4, 1, 1);
        wr_en = 1'b1; wr_sel = 4'b0011; wr_data = 4'd9;
        tick();
        wr_en = 1'b0; wr_sel = '0;
        check("t3_badsel", 64'(sorted_bus), 64'h1144);
        run_sort(1'b1, 1'b0, 0, 0, n);
        check("t3_cycles", 64'(n), 64'(12));
        check("t3_bus", 64'(sorted_bus), 64'h4411);
        check("t3_cnt", 64'(swap_cnt), 64'(4));

        // Same-edge write of entry 3 and start.
        load4(1, 2, 3, 5);
        run_sort(1'b0, 1'b1, 3, 0, n);
        check("t4_bus", 64'(sorted_bus), 64'h3210);
        check("t4_cnt", 64'(swap_cnt), 64'(3));

        // Reset mid-pass, then a fresh sort.
        load4(3, 1, 2, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        pulse_reset();
        load4(3, 1, 2, 0);
        run_sort(1'b0, 1'b0, 0, 0, n);
        check("t5_cycles", 64'(n), 64'(12));
        check("t5_bus", 64'(sorted_bus), 64'h3210);

        // Randomized traffic checked cycle by cycle.
        for (int k = 0; k < 3000; k++) begin
            wr_en   = ($urandom_range(3) == 0);
            wr_sel  = ($urandom_range(2) == 0) ? DEPTH'($urandom) : (DEPTH'(1) << $urandom_range(DEPTH-1));
            wr_data = WIDTH'($urandom);
            start   = ($urandom_range(7) == 0);
            if ($urandom_range(499) == 0) begin
                pulse_reset();
            end else begin
                tick();
            end
        end
        wr_en = 1'b0; wr_sel = '0; start = 1'b0;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
